// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the instruction-memory read port between CPU fetch
// and the debug/trace reader. Fetch has fixed priority. A saturating wait
// counter forces a debug grant after MAX_WAIT consecutive denied cycles.
// Read data returns through a two-stage tag pipeline, two cycles after grant.
// Optional feature macro: IMEM_ARB_STATS_EN adds saturating 16-bit grant
// counters (stat_f_cnt, stat_d_cnt, stat_force_cnt).
module imem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
`ifdef IMEM_ARB_STATS_EN
  output logic [15:0]       stat_f_cnt,
  output logic [15:0]       stat_d_cnt,
  output logic [15:0]       stat_force_cnt,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic              force_s;
  logic              d_gnt_s;
  logic              f_gnt_s;
  logic [ADDR_W-1:0] mem_addr_s;

  logic [ADDR_W-1:0] last_addr_q;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic              s1_valid_q;
  logic              s1_owner_q;   // 1'b1 = debug owns the in-flight read
  logic              f_rvalid_q, d_rvalid_q;
  logic [DATA_W-1:0] f_rdata_q, d_rdata_q;

  // Grant decision and memory address steering for the current cycle.
  always_comb begin
    force_s = d_req && (wait_cnt_q == MAX_WAIT_C);
    d_gnt_s = d_req && (!f_req || force_s);
    f_gnt_s = f_req && !d_gnt_s;
    if (d_gnt_s) begin
      mem_addr_s = d_addr;
    end else if (f_gnt_s) begin
      mem_addr_s = f_addr;
    end else begin
      mem_addr_s = last_addr_q;
    end
  end

  // Starvation counter next state: counts consecutive denied debug cycles.
  always_comb begin
    if (!d_req || d_gnt_s) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q < MAX_WAIT_C) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // Arbitration state and tag pipeline; reset drops any in-flight read.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_addr_q <= '0;
      wait_cnt_q  <= 4'd0;
      s1_valid_q  <= 1'b0;
      s1_owner_q  <= 1'b0;
      f_rvalid_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
      f_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      if (f_gnt_s || d_gnt_s) begin
        last_addr_q <= mem_addr_s;
      end
      s1_valid_q <= f_gnt_s || d_gnt_s;
      s1_owner_q <= d_gnt_s;
      f_rvalid_q <= s1_valid_q && !s1_owner_q;
      d_rvalid_q <= s1_valid_q && s1_owner_q;
      if (s1_valid_q && !s1_owner_q) begin
        f_rdata_q <= mem_dout;
      end
      if (s1_valid_q && s1_owner_q) begin
        d_rdata_q <= mem_dout;
      end
    end
  end

`ifdef IMEM_ARB_STATS_EN
  logic [15:0] stat_f_q, stat_d_q, stat_force_q;

  // Saturating grant statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_f_q     <= 16'd0;
      stat_d_q     <= 16'd0;
      stat_force_q <= 16'd0;
    end else begin
      if (f_gnt_s && (stat_f_q != 16'hFFFF)) begin
        stat_f_q <= stat_f_q + 16'd1;
      end
      if (d_gnt_s && (stat_d_q != 16'hFFFF)) begin
        stat_d_q <= stat_d_q + 16'd1;
      end
      if (force_s && (stat_force_q != 16'hFFFF)) begin
        stat_force_q <= stat_force_q + 16'd1;
      end
    end
  end

  assign stat_f_cnt     = stat_f_q;
  assign stat_d_cnt     = stat_d_q;
  assign stat_force_cnt = stat_force_q;
`endif

  assign f_gnt    = f_gnt_s;
  assign d_gnt    = d_gnt_s;
  assign mem_addr = mem_addr_s;
  assign f_rvalid = f_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign f_rdata  = f_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Two-port arbiter that shares the single read port of the dual-ROM instruction memory between the CPU fetch stage and the debug/trace read port. It grants one read per cycle, routes the address to the memory, and returns data to the right requester through a two-stage tag pipeline. Fetch has fixed priority, and a bounded-starvation counter guarantees debug progress. It sits between the fetch stage / debug unit and `InstMemory`.

## Interface
Parameters:
- ADDR_W, 10, word address width; matches instruction-memory address (bit ADDR_W-1 selects ROM half)
- DATA_W, 32, instruction word width
- MAX_WAIT, 4, consecutive denied debug cycles before debug is forced to win (1..15)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- f_req  in  1  fetch read request
- f_addr  in  ADDR_W  fetch word address
- f_gnt  out  1  fetch request accepted this cycle (combinational)
- f_rvalid  out  1  fetch read data valid (one-cycle pulse)
- f_rdata  out  DATA_W  fetch read data
- d_req / d_addr / d_gnt / d_rvalid / d_rdata  same as fetch, for the debug port
- mem_addr  out  ADDR_W  address to instruction memory
- mem_dout  in  DATA_W  instruction memory data; valid one cycle after mem_addr

## Operation
- Grant (combinational from req and the starvation counter): force = d_req && (wait_cnt == MAX_WAIT); d_gnt = d_req && (!f_req || force); f_gnt = f_req && !d_gnt. At most one grant per cycle.
- A request is accepted when req && gnt. The address must be held by the requester until granted.
- mem_addr = granted requester's addr in the grant cycle. Otherwise it holds last_addr, a register updated on every grant.
- wait_cnt (4 bits): cleared when d_req is low or d_gnt is high. It increments when d_req && !d_gnt, saturating at MAX_WAIT.
- Tag pipeline:
  - Stage 1 register: {valid, owner} captured at the grant cycle.
  - Stage 2: on the next edge, mem_dout is registered into owner's rdata, and owner's rvalid is pulsed.
  - The non-owner's rdata holds its previous value.
- Fully pipelined: back-to-back grants every cycle. Each accepted request yields exactly one rvalid, in order.
- Reset:
  - last_addr, wait_cnt, stage-1 valid, f_rvalid, d_rvalid = 0.
  - f_rdata, d_rdata = 0.
  - Reset mid-operation drops in-flight reads: no rvalid is produced for requests granted in the cycle of, or the cycle before, reset.

## Timing
- Grant in cycle N (same cycle as req, if it wins).
- mem_addr valid in cycle N; mem_dout is sampled at the edge ending N+1.
- rvalid/rdata are visible in cycle N+2. Fixed latency: 2 cycles from accept to data.
- Simultaneous f_req and d_req: fetch wins unless wait_cnt == MAX_WAIT. Under constant contention, debug wins exactly 1 in MAX_WAIT+1 cycles.
- No backpressure on responses. Requesters must accept rvalid when it fires.
- Address wrap: no arithmetic on addresses; any ADDR_W value is passed unchanged, including the ROM-half boundary (511 -> 512).

## Configuration
- IMEM_ARB_STATS_EN defined: adds three outputs, each 16 bits, saturating at 0xFFFF and cleared on reset:
  - stat_f_cnt (fetch grants)
  - stat_d_cnt (debug grants)
  - stat_force_cnt (grants where force was high)
- IMEM_ARB_STATS_EN undefined: these ports and counters are absent; all other behaviour is identical.

## Test plan
- Single fetch:
  - Stimulus: f_req=1, f_addr=2 for one cycle; memory preloaded word 2 = 0x8C010004.
  - Expected: f_gnt=1 in that cycle and mem_addr=2; f_rvalid=1 with f_rdata=0x8C010004 two cycles later; d_rvalid stays 0.
- Contention, MAX_WAIT=4:
  - Stimulus: f_req and d_req held high for 10 cycles.
  - Expected grant sequence: F,F,F,F,D,F,F,F,F,D. Responses arrive in the same order 2 cycles later.
- Half boundary:
  - Stimulus: fetch 511, then 512, then 513 on consecutive cycles.
  - Expected: three consecutive f_rvalid pulses carrying ROM1[511], ROM2[0], ROM2[1].
- Debug alone:
  - Stimulus: d_req=1, d_addr=514, f_req=0.
  - Expected: immediate d_gnt and wait_cnt stays 0; d_rdata=ROM2[2] at N+2; f_rdata unchanged.
- Reset mid-flight:
  - Stimulus: grant a fetch at cycle N, then assert reset in N+1.
  - Expected: no f_rvalid at N+2, all outputs 0, mem_addr=0. A fresh request after reset completes normally.
- With IMEM_ARB_STATS_EN:
  - Stimulus: rerun the contention test.
  - Expected: stat_f_cnt=8, stat_d_cnt=2, stat_force_cnt=2.
